paddle_emu: RTL and testbench

//  Converts PS/2 mouse packets from hps_io into two Atari paddle positions plus two fire buttons.

---
 rtl/a26_pkg.sv | 31 +++
 rtl/paddle_emu_if.sv | 23 ++
 rtl/paddle_axis.sv | 66 ++++++
 rtl/paddle_emu.sv | 108 ++++++++++
 tb/tb_paddle_emu.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/a26_pkg.sv
// Shared constants, types and helpers for the Atari paddle emulation.
// Combinational helpers only; no latency; no flow control.
// Backpressure: none.
package a26_pkg;

    localparam int MOUSE_STB_BIT = 24;
    localparam int MOUSE_XS_BIT  = 4;
    localparam int MOUSE_YS_BIT  = 5;

    localparam logic signed [7:0] PADDLE_MIN = 8'sh80;
    localparam logic signed [7:0] PADDLE_MAX = 8'sh7F;

    typedef logic signed [8:0] delta_t;

    typedef enum logic {
        MODE_JOY   = 1'b0,
        MODE_MOUSE = 1'b1
    } mode_e;

    // Clamp a 10-bit accumulator sum into the 8-bit paddle range.
    function automatic logic [7:0] sat_paddle(input logic signed [9:0] s);
        if (s > 10'(PADDLE_MAX)) begin
            return PADDLE_MAX;
        end
        if (s < 10'(PADDLE_MIN)) begin
            return PADDLE_MIN;
        end
        return s[7:0];
    endfunction

endpackage

// File: rtl/paddle_emu_if.sv
// Bundle of hps_io inputs and paddle/button outputs of the paddle emulator.
// Wires only; no latency.
// Backpressure: none.
interface paddle_emu_if;
    logic [24:0] ps2_mouse;
    logic [15:0] joya_0;
    logic [15:0] joy_0;
    logic [7:0]  paddle_x;
    logic [7:0]  paddle_y;
    logic        btn_a;
    logic        btn_b;
    logic        mouse_active;

    modport master (
        output ps2_mouse, joya_0, joy_0,
        input  paddle_x, paddle_y, btn_a, btn_b, mouse_active
    );

    modport slave (
        input  ps2_mouse, joya_0, joy_0,
        output paddle_x, paddle_y, btn_a, btn_b, mouse_active
    );
endinterface

// File: rtl/paddle_axis.sv
// One paddle axis: shift/clamp a raw mouse delta, then saturating accumulate.
// Latency: delta captured 1 clock after load, accumulated on the following upd.
// Backpressure: none; clear wins over a same-cycle update.
module paddle_axis
    import a26_pkg::*;
#(
    parameter int DELTA_SHIFT = 1,
    parameter int MAX_STEP    = 10
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       load,
    input  logic       upd,
    input  logic       clear,
    input  logic       sgn,
    input  logic [7:0] mag,
    output logic [7:0] acc
);

    localparam delta_t STEP_LIM = delta_t'(MAX_STEP);

    delta_t            d9;
    delta_t            ds;
    delta_t            dc_d;
    delta_t            dc_q;
    logic signed [9:0] sum;
    logic [7:0]        acc_d;
    logic [7:0]        acc_q;

    always_comb begin
        d9   = delta_t'({sgn, mag});
        ds   = d9 >>> DELTA_SHIFT;
        dc_d = dc_q;
        if (load) begin
            if (ds > STEP_LIM) begin
                dc_d = STEP_LIM;
            end else if (ds < -STEP_LIM) begin
                dc_d = -STEP_LIM;
            end else begin
                dc_d = ds;
            end
        end

        // 10 bits holds any 8-bit position plus a clamped 9-bit delta.
        sum   = {{2{acc_q[7]}}, acc_q} + {dc_q[8], dc_q};
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (upd) begin
            acc_d = sat_paddle(sum);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dc_q  <= '0;
            acc_q <= '0;
        end else begin
            dc_q  <= dc_d;
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/paddle_emu.sv
// PS/2 mouse / analog stick to two Atari paddles plus fire buttons.
// Latency: paddle outputs follow a packet 2 clocks after its toggle is sampled.
// Backpressure: none; packets at most every 2 clocks, analog activity overrides.
module paddle_emu
    import a26_pkg::*;
#(
    parameter int DELTA_SHIFT = 1,
    parameter int MAX_STEP    = 10
) (
    input  logic         clk_sys,
    input  logic         reset,
    paddle_emu_if.slave  bus
);

    logic       stb_d, stb_q;
    logic       pkt;
    logic       override;
    logic       v1_d, v1_q;
    mode_e      mode_d, mode_q;
    logic [7:0] acc_x, acc_y;
    logic [7:0] paddle_x_d, paddle_x_q;
    logic [7:0] paddle_y_d, paddle_y_q;
    logic       btn_a_d, btn_a_q;
    logic       btn_b_d, btn_b_q;
    logic       mouse_active_d, mouse_active_q;
    logic       unused_ok;

    assign stb_d    = bus.ps2_mouse[MOUSE_STB_BIT];
    assign pkt      = stb_d != stb_q;
    assign override = bus.joya_0 != 16'h0000;

    paddle_axis #(.DELTA_SHIFT(DELTA_SHIFT), .MAX_STEP(MAX_STEP)) u_axis_x (
        .clk_sys (clk_sys),
        .reset   (reset),
        .load    (pkt),
        .upd     (v1_q),
        .clear   (override),
        .sgn     (bus.ps2_mouse[MOUSE_XS_BIT]),
        .mag     (bus.ps2_mouse[15:8]),
        .acc     (acc_x)
    );

    paddle_axis #(.DELTA_SHIFT(DELTA_SHIFT), .MAX_STEP(MAX_STEP)) u_axis_y (
        .clk_sys (clk_sys),
        .reset   (reset),
        .load    (pkt),
        .upd     (v1_q),
        .clear   (override),
        .sgn     (bus.ps2_mouse[MOUSE_YS_BIT]),
        .mag     (bus.ps2_mouse[23:16]),
        .acc     (acc_y)
    );

    always_comb begin
        v1_d   = pkt & ~override;
        mode_d = mode_q;
        case (mode_q)
            MODE_JOY:   if (v1_q && !override) mode_d = MODE_MOUSE;
            MODE_MOUSE: if (override)          mode_d = MODE_JOY;
            default:                           mode_d = MODE_JOY;
        endcase

        paddle_x_d     = bus.joya_0[7:0];
        paddle_y_d     = bus.joya_0[15:8];
        btn_a_d        = bus.joy_0[5];
        btn_b_d        = bus.joy_0[6];
        mouse_active_d = 1'b0;
        if (mode_q == MODE_MOUSE) begin
            paddle_x_d     = acc_x;
            paddle_y_d     = acc_y;
            btn_a_d        = bus.ps2_mouse[0];
            btn_b_d        = bus.ps2_mouse[1];
            mouse_active_d = 1'b1;
        end
    end

    // Strobe tracks the input even in reset so a toggle seen then is absorbed.
    always_ff @(posedge clk_sys) begin
        stb_q <= stb_d;
        if (reset) begin
            v1_q           <= 1'b0;
            mode_q         <= MODE_JOY;
            paddle_x_q     <= '0;
            paddle_y_q     <= '0;
            btn_a_q        <= bus.joy_0[5];
            btn_b_q        <= bus.joy_0[6];
            mouse_active_q <= 1'b0;
        end else begin
            v1_q           <= v1_d;
            mode_q         <= mode_d;
            paddle_x_q     <= paddle_x_d;
            paddle_y_q     <= paddle_y_d;
            btn_a_q        <= btn_a_d;
            btn_b_q        <= btn_b_d;
            mouse_active_q <= mouse_active_d;
        end
    end

    assign bus.paddle_x     = paddle_x_q;
    assign bus.paddle_y     = paddle_y_q;
    assign bus.btn_a        = btn_a_q;
    assign bus.btn_b        = btn_b_q;
    assign bus.mouse_active = mouse_active_q;

    assign unused_ok = ^{bus.ps2_mouse[7:6], bus.ps2_mouse[3:2],
                         bus.joy_0[15:7], bus.joy_0[4:0]};

endmodule

// File: tb/tb_paddle_emu.sv
// Randomized and directed checks of paddle_emu against an integer reference model.
module tb_paddle_emu;

    localparam int SHIFT_DIV = 2;
    localparam int STEP_MAX  = 10;

    logic clk_sys = 1'b0;
    logic reset;

    paddle_emu_if bus();

    paddle_emu #(.DELTA_SHIFT(1), .MAX_STEP(STEP_MAX)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_pass   = 0;

    int m_x = 0;
    int m_y = 0;
    bit m_mouse = 1'b0;

    logic [18:0] obs;
    assign obs = {bus.paddle_x, bus.paddle_y, bus.btn_a, bus.btn_b, bus.mouse_active};

    // Reference: signed delta, floor-divided, clamped, added, then clamped to paddle range.
    function automatic int step(input int acc, input logic s, input logic [7:0] b);
        int d, ds, r;
        d  = s ? int'(b) - 256 : int'(b);
        ds = (d >= 0) ? d / SHIFT_DIV : -((SHIFT_DIV - 1 - d) / SHIFT_DIV);
        if (ds > STEP_MAX)  ds = STEP_MAX;
        if (ds < -STEP_MAX) ds = -STEP_MAX;
        r = acc + ds;
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    function automatic logic [18:0] mdl_vec(input logic [1:0] btn);
        if (m_mouse)
            return {m_x[7:0], m_y[7:0], btn[0], btn[1], 1'b1};
        return {bus.joya_0[7:0], bus.joya_0[15:8], bus.joy_0[5], bus.joy_0[6], 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send(input logic xs, input logic [7:0] dx,
                        input logic ys, input logic [7:0] dy, input logic [1:0] btn);
        bus.ps2_mouse = {~bus.ps2_mouse[24], dy, dx, 2'b00, ys, xs, 2'b00, btn};
        m_x     = step(m_x, xs, dx);
        m_y     = step(m_y, ys, dy);
        m_mouse = 1'b1;
    endtask

    task automatic test_reset();
        logic [18:0] exp;
        reset = 1'b1;
        bus.joya_0 = 16'h1234;
        bus.joy_0  = 16'h0020;
        tick(); tick();
        exp = {16'h0000, 1'b1, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp) $display("FAIL reset_hold: got %h want %h", obs, exp);
        else n_pass++;

        bus.ps2_mouse[24] = ~bus.ps2_mouse[24];
        tick(); tick();
        reset = 1'b0;
        bus.joya_0 = 16'h0000;
        bus.joy_0  = 16'h0000;
        tick(); tick(); tick(); tick();
        n_checks++;
        if (obs !== 19'h0) $display("FAIL reset_absorb: got %h want %h", obs, 19'h0);
        else n_pass++;
    endtask

    task automatic test_clamp();
        logic [18:0] exp;
        send(1'b0, 8'h28, 1'b0, 8'h00, 2'b00);
        tick(); tick();
        n_checks++;
        if (obs !== 19'h0) $display("FAIL latency_early: got %h want %h", obs, 19'h0);
        else n_pass++;
        tick();
        exp = mdl_vec(2'b00);
        n_checks++;
        if (obs !== exp) $display("FAIL clamp_x: got %h want %h", obs, exp);
        else n_pass++;
        n_checks++;
        if (bus.paddle_x !== 8'd10) $display("FAIL clamp_x_value: got %0d want 10", bus.paddle_x);
        else n_pass++;
    endtask

    task automatic test_sat_x();
        logic [18:0] exp;
        for (int i = 0; i < 50; i++) begin
            send(1'b0, 8'h06, 1'b0, 8'h00, 2'b00);
            tick(); tick(); tick();
            exp = mdl_vec(2'b00);
            n_checks++;
            if (obs !== exp) $display("FAIL sat_x_step%0d: got %h want %h", i, obs, exp);
            else n_pass++;
        end
        n_checks++;
        if (bus.paddle_x !== 8'h7F) $display("FAIL sat_x_hold: got %h want 7f", bus.paddle_x);
        else n_pass++;
        send(1'b1, 8'hF8, 1'b0, 8'h00, 2'b00);
        tick(); tick(); tick();
        n_checks++;
        if (bus.paddle_x !== 8'd123) $display("FAIL sat_x_away: got %0d want 123", bus.paddle_x);
        else n_pass++;
    endtask

    task automatic test_sat_y();
        logic [18:0] exp;
        for (int i = 0; i < 17; i++) begin
            send(1'b0, 8'h00, 1'b1, 8'hF0, 2'b00);
            tick(); tick(); tick();
            exp = mdl_vec(2'b00);
            n_checks++;
            if (obs !== exp) $display("FAIL sat_y_step%0d: got %h want %h", i, obs, exp);
            else n_pass++;
            if (i == 0) begin
                n_checks++;
                if (bus.paddle_y !== 8'hF8) $display("FAIL sat_y_first: got %h want f8", bus.paddle_y);
                else n_pass++;
            end
        end
        n_checks++;
        if (bus.paddle_y !== 8'h80) $display("FAIL sat_y_floor: got %h want 80", bus.paddle_y);
        else n_pass++;
    endtask

    task automatic test_override();
        logic [18:0] exp;
        send(1'b0, 8'h02, 1'b0, 8'h00, 2'b00);
        tick();
        bus.joya_0 = 16'h3050;
        tick(); tick();
        m_x = 0; m_y = 0; m_mouse = 1'b0;
        exp = {8'h50, 8'h30, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp) $display("FAIL override: got %h want %h", obs, exp);
        else n_pass++;
        bus.joya_0 = 16'h0000;
        tick();
        send(1'b0, 8'h02, 1'b0, 8'h00, 2'b00);
        tick(); tick(); tick();
        exp = mdl_vec(2'b00);
        n_checks++;
        if (obs !== exp || bus.paddle_x !== 8'd1)
            $display("FAIL override_resume: got %h want %h", obs, exp);
        else n_pass++;
    endtask

    task automatic test_buttons();
        bus.ps2_mouse[1:0] = 2'b01;
        tick(); tick();
        n_checks++;
        if ({bus.btn_a, bus.btn_b, bus.mouse_active} !== 3'b101)
            $display("FAIL btn_mouse: got %b want 101", {bus.btn_a, bus.btn_b, bus.mouse_active});
        else n_pass++;
        bus.joya_0 = 16'h0001;
        bus.joy_0  = 16'h0040;
        bus.ps2_mouse[1:0] = 2'b11;
        tick(); tick(); tick();
        n_checks++;
        if ({bus.btn_a, bus.btn_b, bus.mouse_active, bus.paddle_x} !== {3'b010, 8'h01})
            $display("FAIL btn_joy: got %b/%h want 010/01",
                     {bus.btn_a, bus.btn_b, bus.mouse_active}, bus.paddle_x);
        else n_pass++;
        m_x = 0; m_y = 0; m_mouse = 1'b0;
        bus.joya_0 = 16'h0000;
        bus.joy_0  = 16'h0000;
        bus.ps2_mouse[1:0] = 2'b00;
        tick(); tick();
    endtask

    task automatic test_back_to_back();
        logic [18:0] exp;
        logic [7:0]  px, py;
        logic [1:0]  btn;
        bit          pm;
        for (int i = 0; i < 150; i++) begin
            px  = m_x[7:0];
            py  = m_y[7:0];
            pm  = m_mouse;
            btn = 2'($urandom_range(0, 3));
            send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), btn);
            tick(); tick();
            exp = pm ? {px, py, btn[0], btn[1], 1'b1} : 19'h0;
            n_checks++;
            if (obs !== exp) $display("FAIL b2b_%0d: got %h want %h", i, obs, exp);
            else n_pass++;
        end
        tick();
        exp = mdl_vec(bus.ps2_mouse[1:0]);
        n_checks++;
        if (obs !== exp) $display("FAIL b2b_last: got %h want %h", obs, exp);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [18:0] exp;
        send(1'b0, 8'h14, 1'b0, 8'h00, 2'b00);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_x = 0; m_y = 0; m_mouse = 1'b0;
        tick(); tick();
        n_checks++;
        if (obs !== 19'h0) $display("FAIL reset_mid: got %h want %h", obs, 19'h0);
        else n_pass++;
        send(1'b0, 8'h02, 1'b0, 8'h00, 2'b00);
        tick(); tick(); tick();
        exp = mdl_vec(2'b00);
        n_checks++;
        if (obs !== exp) $display("FAIL reset_mid_lost: got %h want %h", obs, exp);
        else n_pass++;
    endtask

    initial begin
        reset         = 1'b1;
        bus.ps2_mouse = '0;
        bus.joya_0    = '0;
        bus.joy_0     = '0;
        test_reset();
        test_clamp();
        test_sat_x();
        test_sat_y();
        test_override();
        test_buttons();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
